// File: rtl/butterfly2_param.sv
// Pipelined radix-2 DIT butterfly with twiddle multiply on the B leg.
// It generates its own twiddle ROM address and applies optional /2 scaling, rounding and saturation.
module butterfly2_param #(
   parameter int   DW    = 16,
   parameter int   TW    = 16,
   parameter int   LOG2N = 10,
   parameter logic SCALE = 1'b1,
   parameter int   SW    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 sop,
   input  logic [SW-1:0]        stage,
   input  logic                 scale_en,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] dina_r,
   input  logic signed [DW-1:0] dina_i,
   input  logic signed [DW-1:0] dinb_r,
   input  logic signed [DW-1:0] dinb_i,
   output logic [LOG2N-2:0]     rom_ad,
   input  logic [2*TW-1:0]      rom_out,
   output logic                 out_valid,
   output logic signed [DW-1:0] douta_r,
   output logic signed [DW-1:0] douta_i,
   output logic signed [DW-1:0] doutb_r,
   output logic signed [DW-1:0] doutb_i,
   output logic                 ovf
);

   // Handshake: a pair is accepted on every ce edge with in_valid=1 (no backpressure);
   // out_valid=1 marks a fresh result registered on a ce edge exactly 4 ce-cycles later.
   localparam int AW = LOG2N - 1;
   localparam int PW = DW + TW;
   localparam logic signed [PW:0]   RND  = (PW+1)'(1) << (TW-2);
   localparam logic signed [DW+1:0] ONE  = (DW+2)'(1);
   localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};

   function automatic logic [AW-1:0] twiddle_addr(input logic [AW-1:0] jj, input logic [SW-1:0] s);
      logic [AW-1:0] mask;
      int            sh;
      sh   = (int'(s) > AW) ? 0 : AW - int'(s);
      mask = ~({AW{1'b1}} << s);
      return (jj & mask) << sh;
   endfunction

   // Returns {saturated, value}.
   function automatic logic [DW:0] sat_scale(input logic signed [DW+1:0] x, input logic sc);
      logic signed [DW+1:0] y;
      y = sc ? ((x + ONE) >>> 1) : x;
      if (y > MAXV)      return {1'b1, MAXV[DW-1:0]};
      else if (y < MINV) return {1'b1, MINV[DW-1:0]};
      return {1'b0, y[DW-1:0]};
   endfunction

   logic [AW-1:0] j, j_eff;
   logic [SW-1:0] stage_q, s_eff;
   logic          scale_q, sc_eff;

   assign j_eff  = sop ? '0 : j;
   assign s_eff  = sop ? stage : stage_q;
   assign sc_eff = sop ? scale_en : scale_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         j       <= '0;
         stage_q <= '0;
         scale_q <= SCALE;
         rom_ad  <= '0;
      end else if (ce) begin
         if (sop) begin
            stage_q <= stage;
            scale_q <= scale_en;
         end
         if (in_valid) begin
            j      <= j_eff + 1'b1;
            rom_ad <= twiddle_addr(j_eff, s_eff);
         end else if (sop) begin
            j <= '0;
         end
      end
   end

   logic                 v1, v2, v3, sc1, sc2, sc3;
   logic signed [DW-1:0] a1_r, a1_i, b1_r, b1_i;
   logic signed [DW-1:0] a2_r, a2_i, b2_r, b2_i;
   logic signed [DW-1:0] a3_r, a3_i;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [TW-1:0] w_r, w_i;

   assign w_r = rom_out[2*TW-1:TW];
   assign w_i = rom_out[TW-1:0];

   // Stage 2 only waits for the registered ROM read; products are formed once rom_out is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         sc1 <= 1'b0; sc2 <= 1'b0; sc3 <= 1'b0;
         a1_r <= '0; a1_i <= '0; b1_r <= '0; b1_i <= '0;
         a2_r <= '0; a2_i <= '0; b2_r <= '0; b2_i <= '0;
         a3_r <= '0; a3_i <= '0;
         p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
      end else if (ce) begin
         v1   <= in_valid;
         sc1  <= sc_eff;
         a1_r <= dina_r;
         a1_i <= dina_i;
         b1_r <= dinb_r;
         b1_i <= dinb_i;
         v2   <= v1;
         sc2  <= sc1;
         a2_r <= a1_r;
         a2_i <= a1_i;
         b2_r <= b1_r;
         b2_i <= b1_i;
         v3   <= v2;
         sc3  <= sc2;
         a3_r <= a2_r;
         a3_i <= a2_i;
         p_rr <= PW'(b2_r) * PW'(w_r);
         p_ii <= PW'(b2_i) * PW'(w_i);
         p_ri <= PW'(b2_r) * PW'(w_i);
         p_ir <= PW'(b2_i) * PW'(w_r);
      end
   end

   logic signed [PW:0]   tr_full, ti_full;
   logic signed [DW:0]   t_r, t_i;
   logic signed [DW+1:0] sum_r, sum_i, dif_r, dif_i;
   logic [DW:0]          qa_r, qa_i, qb_r, qb_i;
   logic                 any_sat;
   logic                 unused_bits;

   // Selecting bits [TW-1+DW : TW-1] is the arithmetic shift by TW-1 kept to DW+1 bits.
   always_comb begin
      tr_full = (PW+1)'(p_rr) - (PW+1)'(p_ii) + RND;
      ti_full = (PW+1)'(p_ri) + (PW+1)'(p_ir) + RND;
      t_r     = tr_full[TW-1 +: DW+1];
      t_i     = ti_full[TW-1 +: DW+1];
      sum_r   = (DW+2)'(a3_r) + (DW+2)'(t_r);
      sum_i   = (DW+2)'(a3_i) + (DW+2)'(t_i);
      dif_r   = (DW+2)'(a3_r) - (DW+2)'(t_r);
      dif_i   = (DW+2)'(a3_i) - (DW+2)'(t_i);
      qa_r    = sat_scale(sum_r, sc3);
      qa_i    = sat_scale(sum_i, sc3);
      qb_r    = sat_scale(dif_r, sc3);
      qb_i    = sat_scale(dif_i, sc3);
      any_sat = qa_r[DW] | qa_i[DW] | qb_r[DW] | qb_i[DW];
   end

   assign unused_bits = ^{tr_full[PW], tr_full[TW-2:0], ti_full[PW], ti_full[TW-2:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         douta_r   <= '0;
         douta_i   <= '0;
         doutb_r   <= '0;
         doutb_i   <= '0;
         ovf       <= 1'b0;
      end else if (ce) begin
         out_valid <= v3;
         if (v3) begin
            douta_r <= qa_r[DW-1:0];
            douta_i <= qa_i[DW-1:0];
            doutb_r <= qb_r[DW-1:0];
            doutb_i <= qb_i[DW-1:0];
         end
         if (sop)                ovf <= v3 & any_sat;
         else if (v3 && any_sat) ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_butterfly2_param.sv
// Testbench for butterfly2_param: directed vectors and a stall/bubble run.
// Expected results go into a queue that a monitor compares against each new output.
module tb_butterfly2_param;

   localparam int DW = 16;
   localparam int TW = 16;
   localparam int LOG2N = 10;
   localparam int SW = 4;

   logic              clk = 1'b0;
   logic              rst, ce, sop, scale_en, in_valid;
   logic [SW-1:0]     stage;
   logic [DW-1:0]     dina_r, dina_i, dinb_r, dinb_i;
   logic [LOG2N-2:0]  rom_ad;
   logic [2*TW-1:0]   rom_out, rom_fixed;
   logic              rom_use_tbl;
   logic              out_valid, ovf;
   logic [DW-1:0]     douta_r, douta_i, doutb_r, doutb_i;

   int          checks = 0;
   int          errors = 0;
   int          ce_cnt = 0;
   logic        ce_edge = 1'b0;
   logic [95:0] exp_q[$];
   logic [95:0] mon_e;

   butterfly2_param #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .SCALE(1'b1), .SW(SW)) dut (
      .clk(clk), .rst(rst), .ce(ce), .sop(sop), .stage(stage), .scale_en(scale_en),
      .in_valid(in_valid), .dina_r(dina_r), .dina_i(dina_i), .dinb_r(dinb_r), .dinb_i(dinb_i),
      .rom_ad(rom_ad), .rom_out(rom_out), .out_valid(out_valid),
      .douta_r(douta_r), .douta_i(douta_i), .doutb_r(doutb_r), .doutb_i(doutb_i), .ovf(ovf)
   );

   // ---------------- clock / reset / external ROM ----------------
   always #5 clk = ~clk;

   function automatic logic [2*TW-1:0] tbl(input logic [LOG2N-2:0] a);
      int wr, wi;
      wr = int'(a) * 40;
      wi = -int'(a) * 25;
      return {wr[15:0], wi[15:0]};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst)    rom_out <= '0;
      else if (ce) rom_out <= rom_use_tbl ? tbl(rom_ad) : rom_fixed;
   end

   always @(posedge clk) begin
      ce_edge <= ce && rst;
      if (ce && rst) ce_cnt <= ce_cnt + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] model(input int ar, ai, br, bi, wr, wi, input bit sc);
      longint t_r, t_i;
      longint s [4];
      logic [63:0] r;
      t_r = (longint'(br) * longint'(wr) - longint'(bi) * longint'(wi) + 64'sd16384) >>> 15;
      t_i = (longint'(br) * longint'(wi) + longint'(bi) * longint'(wr) + 64'sd16384) >>> 15;
      s[0] = ar + t_r;
      s[1] = ai + t_i;
      s[2] = ar - t_r;
      s[3] = ai - t_i;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         if (sc) s[k] = (s[k] + 1) >>> 1;
         if (s[k] > 32767) s[k] = 32767;
         else if (s[k] < -32768) s[k] = -32768;
         r[63-16*k -: 16] = s[k][15:0];
      end
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_data(input logic [63:0] d);
      int e;
      e = ce_cnt + 4;
      exp_q.push_back({e, d});
   endtask

   task automatic push_exp(input int a_r, a_i, b_r, b_i);
      push_data({a_r[15:0], a_i[15:0], b_r[15:0], b_i[15:0]});
   endtask

   task automatic issue(input bit s, input int st, input bit sc, input int ar, ai, br, bi);
      sop      = s;
      stage    = st[SW-1:0];
      scale_en = sc;
      in_valid = 1'b1;
      dina_r   = ar[15:0];
      dina_i   = ai[15:0];
      dinb_r   = br[15:0];
      dinb_i   = bi[15:0];
      tick();
      sop      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d results still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst && ce_edge && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: actual out_valid=1 required no pending pair");
         end else begin
            mon_e = exp_q.pop_front();
            check("dout", {douta_r, douta_i, doutb_r, doutb_i}, mon_e[63:0]);
            check("latency", 64'(ce_cnt), 64'(mon_e[95:64]));
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] snap_d;
      logic [9:0]  snap_c;
      logic [31:0] w;
      logic signed [15:0] w16r, w16i;
      int ar, ai, br, bi, k;

      rst = 1'b0; ce = 1'b1; sop = 1'b0; stage = '0; scale_en = 1'b0; in_valid = 1'b0;
      dina_r = '0; dina_i = '0; dinb_r = '0; dinb_i = '0;
      rom_fixed = '0; rom_use_tbl = 1'b0;
      repeat (3) tick();
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_dout", {douta_r, douta_i, doutb_r, doutb_i}, 64'd0);
      check("reset_rom_ad", 64'(rom_ad), 64'd0);
      check("reset_ovf", 64'(ovf), 64'd0);
      rst = 1'b1;
      tick();

      // unity twiddle, no scaling
      rom_fixed = {16'h7FFF, 16'h0000};
      push_exp(3000, -500, -1000, 500);
      issue(1'b1, 0, 1'b0, 1000, 0, 2000, -500);
      drain("unity");
      check("unity_ovf", 64'(ovf), 64'd0);

      // -j twiddle
      rom_fixed = {16'h0000, 16'h8000};
      push_exp(0, -1000, 0, 1000);
      issue(1'b1, 0, 1'b0, 0, 0, 1000, 0);
      drain("minus_j");

      // saturation without scaling
      rom_fixed = {16'h7FFF, 16'h0000};
      push_exp(32767, 0, 1, 0);
      issue(1'b1, 0, 1'b0, 32767, 0, 32767, 0);
      drain("sat");
      check("sat_ovf", 64'(ovf), 64'd1);

      // reset mid-stream discards in-flight pairs
      issue(1'b1, 9, 1'b0, 100, 0, 100, 0);
      issue(1'b0, 9, 1'b0, 100, 0, 100, 0);
      issue(1'b0, 9, 1'b0, 100, 0, 100, 0);
      check("prereset_rom_ad", 64'(rom_ad), 64'd2);
      rst = 1'b0;
      #1;
      exp_q.delete();
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_dout", {douta_r, douta_i, doutb_r, doutb_i}, 64'd0);
      check("midreset_rom_ad", 64'(rom_ad), 64'd0);
      check("midreset_ovf", 64'(ovf), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // scaled repeat of the saturating vector
      push_exp(32767, 0, 1, 0);
      issue(1'b1, 9, 1'b1, 32767, 0, 32767, 0);
      check("post_reset_rom_ad0", 64'(rom_ad), 64'd0);
      push_exp(32767, 0, 1, 0);
      issue(1'b0, 9, 1'b1, 32767, 0, 32767, 0);
      check("post_reset_rom_ad1", 64'(rom_ad), 64'd1);
      drain("scaled");
      check("scaled_ovf", 64'(ovf), 64'd0);

      // address generation
      for (int i = 0; i < 8; i++) begin
         push_exp(0, 0, 0, 0);
         issue(i == 0, 1, 1'b0, 0, 0, 0, 0);
         check("addr_stage1", 64'(rom_ad), 64'((i % 2) * 256));
      end
      drain("addr_stage1");
      for (int i = 0; i < 513; i++) begin
         push_exp(0, 0, 0, 0);
         issue(i == 0, 9, 1'b0, 0, 0, 0, 0);
         check("addr_stage9", 64'(rom_ad), 64'(i % 512));
      end
      drain("addr_stage9");

      // bubbles and a 3-cycle ce stall with a varying twiddle table
      rom_use_tbl = 1'b1;
      k = 0;
      for (int i = 0; i < 30; i++) begin
         if (i != 0) idle($urandom_range(0, 2));
         if (i == 15) begin
            snap_d = {douta_r, douta_i, doutb_r, doutb_i};
            snap_c = {out_valid, rom_ad};
            ce = 1'b0;
            sop = 1'b1;
            in_valid = 1'b1;
            dina_r = 16'h1234; dinb_r = 16'h4321;
            repeat (3) begin
               tick();
               check("stall_dout", {douta_r, douta_i, doutb_r, doutb_i}, snap_d);
               check("stall_ctl", 64'({out_valid, rom_ad}), 64'(snap_c));
            end
            sop = 1'b0;
            in_valid = 1'b0;
            ce = 1'b1;
         end
         ar = int'($urandom_range(0, 16000)) - 8000;
         ai = int'($urandom_range(0, 16000)) - 8000;
         br = int'($urandom_range(0, 16000)) - 8000;
         bi = int'($urandom_range(0, 16000)) - 8000;
         w = tbl(10'(k % 512));
         w16r = w[31:16];
         w16i = w[15:0];
         push_data(model(ar, ai, br, bi, int'(w16r), int'(w16i), 1'b0));
         issue(i == 0, 9, 1'b0, ar, ai, br, bi);
         check("stall_run_rom_ad", 64'(rom_ad), 64'(k % 512));
         k++;
      end
      drain("stall");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
